uart_tx_arbiter: RTL and testbench

- Shares the single `uart_transmitter_controler` between two byte sources: requester 0 (CPU console output FIFO) and requester 1 (receive-echo/monitor FIFO).
- Pops bytes from the requesters' FIFO read ports into a one-entry output buffer, using round-robin arbitration.
- Presents that buffer to the transmitter as a FIFO read port (`dout`/`empty`/`re`).
- Optional line lock keeps a whole text line from one requester contiguous on the serial link.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick2.sv | 13 +
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Exports byte_t, ASCII_CR and the line-lock state encoding.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ASCII_CR = 8'h0D;

    typedef enum logic {
        LK_IDLE,
        LK_LOCKED
    } lock_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (combinational).
// Ports: request[1:0] in, last in (previous winner), grant[1:0] out (one-hot or zero).
module rr_pick2 (
    input  logic [1:0] request,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time is served.
    assign grant[0] = request[0] & (~request[1] | last);
    assign grant[1] = request[1] & (~request[0] | ~last);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two FWFT FIFOs.
// Ports: clk, rst (async active-low); din0/empty0/re0, din1/empty1/re1
// requester read ports; dout/empty/re transmitter read port; owner.
// Define UART_TX_ARB_LOCK_EN to build the line-lock FSM (EOL, MAX_LINE).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter byte_t EOL      = ASCII_CR,
    parameter int    MAX_LINE = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din0,
    input  logic       empty0,
    output logic       re0,
    input  logic [7:0] din1,
    input  logic       empty1,
    output logic       re1,
    output logic [7:0] dout,
    output logic       empty,
    input  logic       re,
    output logic       owner
);

    logic [1:0] elig;
    logic [1:0] req;
    logic [1:0] grant;
    logic       can_load;
    logic       load;
    logic       win;
    byte_t      din_sel;

    byte_t buf_data_q, buf_data_d;
    logic  buf_full_q, buf_full_d;
    logic  owner_q, owner_d;
    logic  last_q, last_d;

    assign req      = elig & ~{empty1, empty0};
    assign can_load = ~buf_full_q | re;
    assign load     = can_load & (|req);
    assign win      = grant[1];
    assign din_sel  = win ? din1 : din0;

    rr_pick2 u_pick (
        .request (req),
        .last    (last_q),
        .grant   (grant)
    );

    // Pops are gated by rst so no pulse escapes while reset is held.
    assign re0 = rst & load & ~win;
    assign re1 = rst & load & win;

    always_comb begin
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        owner_d    = owner_q;
        last_d     = last_q;
        if (load) begin
            buf_data_d = din_sel;
            buf_full_d = 1'b1;
            owner_d    = win;
            // A lock release is always a load by the lock owner, so
            // this also hands priority to the other requester.
            last_d     = win;
        end else if (re) begin
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_q <= 8'h00;
            buf_full_q <= 1'b0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    assign dout  = buf_data_q;
    assign empty = ~buf_full_q;
    assign owner = owner_q;

`ifdef UART_TX_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LINE + 1);

    lock_state_e   state_q, state_d;
    logic          lock_owner_q, lock_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_eol;
    logic          at_max;

    assign is_eol = (din_sel == EOL);
    assign at_max = (int'(cnt_q) + 1) == MAX_LINE;

    // While locked, the other requester waits even if the owner is empty.
    assign elig = (state_q == LK_LOCKED)
                ? (lock_owner_q ? 2'b10 : 2'b01)
                : 2'b11;

    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        cnt_d        = cnt_q;
        if (load) begin
            unique case (state_q)
                LK_IDLE: begin
                    if (!is_eol && MAX_LINE > 1) begin
                        state_d      = LK_LOCKED;
                        lock_owner_d = win;
                        cnt_d        = CW'(1);
                    end
                end
                LK_LOCKED: begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_eol || at_max) begin
                        state_d = LK_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = LK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LK_IDLE;
            lock_owner_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            cnt_q        <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign elig       = 2'b11;
    assign unused_cfg = ^{EOL, 8'(MAX_LINE)};
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Lock scenarios are built only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din0, din1;
    logic       empty0, empty1;
    logic       re0, re1;
    logic [7:0] dout;
    logic       empty;
    logic       re = 1'b0;
    logic       owner;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q0 [32];
    logic [7:0] q1 [32];
    int         n0 = 0, n1 = 0;
    int         i0 = 0, i1 = 0;
    logic       clr = 1'b0;
    logic       prot_en = 1'b0;
    logic [7:0] exp_q [16];

    always #5 clk = ~clk;

    assign empty0 = (i0 >= n0);
    assign empty1 = (i1 >= n1);
    assign din0   = (i0 < 32) ? q0[i0] : 8'h00;
    assign din1   = (i1 < 32) ? q1[i1] : 8'h00;

    always @(posedge clk) begin
        if (clr) begin
            i0 <= 0;
            i1 <= 0;
        end else begin
            if (re0) i0 <= i0 + 1;
            if (re1) i1 <= i1 + 1;
        end
    end

    uart_tx_arbiter #(
        .EOL      (8'h0D),
        .MAX_LINE (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din0   (din0),
        .empty0 (empty0),
        .re0    (re0),
        .din1   (din1),
        .empty1 (empty1),
        .re1    (re1),
        .dout   (dout),
        .empty  (empty),
        .re     (re),
        .owner  (owner)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && prot_en) begin
            chk("re0_while_empty0", re0 & empty0, 0);
            chk("re0_re1_both", re0 & re1, 0);
        end
    end

    // Restart both source FIFOs at index 0 with the given lengths.
    task automatic setup(input int a, input int b);
        n0 = 0;
        n1 = 0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n0 = a;
        n1 = b;
    endtask

    task automatic do_reset();
        n0 = 0;
        n1 = 0;
        re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_dout"}, dout, exp_q[k]);
            chk({tag, "_empty"}, empty, 0);
        end
    endtask

    initial begin
        // Reset state.
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_re0", re0, 0);
        chk("rst_re1", re1, 0);
        chk("rst_owner", owner, 0);
        @(negedge clk);
        rst = 1'b1;
        prot_en = 1'b1;

        // Single byte, one pop pulse, one-cycle latency.
        q0[0] = 8'h41;
        setup(1, 0);
        #1;
        chk("t2_re0", re0, 1);
        chk("t2_re1", re1, 0);
        @(posedge clk);
        #1;
        chk("t2_empty", empty, 0);
        chk("t2_dout", dout, 8'h41);
        chk("t2_owner", owner, 0);
        chk("t2_re0_once", re0, 0);
        @(posedge clk);
        #1;
        chk("t2_hold", dout, 8'h41);
        re = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
        chk("t2_pop_empty", empty, 1);
        chk("t2_pop_dout", dout, 8'h41);

        // Asynchronous reset while the buffer is full.
        q0[0] = 8'h41;
        q0[1] = 8'h42;
        setup(1, 0);
        @(posedge clk);
        #1;
        chk("t1_full", empty, 0);
        n0 = 2;
        #1;
        rst = 1'b0;
        #1;
        chk("t1_mid_empty", empty, 1);
        chk("t1_mid_dout", dout, 8'h00);
        chk("t1_mid_re0", re0, 0);
        n0 = 0;
        @(negedge clk);
        rst = 1'b1;

        // Round-robin with both sources always ready.
        for (int k = 0; k < 16; k++) begin
            q0[k] = 8'h30 + 8'(k);
            q1[k] = 8'h61 + 8'(k);
        end
        for (int k = 0; k < 8; k++) begin
            exp_q[2*k]   = 8'h30 + 8'(k);
            exp_q[2*k+1] = 8'h61 + 8'(k);
        end
        setup(16, 16);
        re = 1'b1;
        drain("t3", 12);
        re = 1'b0;

`ifdef UART_TX_ARB_LOCK_EN
        // Line lock: "AB\r" from req0 is not interleaved with 'x'.
        do_reset();
        q0[0] = 8'h41;
        q0[1] = 8'h42;
        q0[2] = 8'h0D;
        q1[0] = 8'h78;
        setup(3, 1);
        re = 1'b1;
        #1;
        chk("t4_re1_c0", re1, 0);
        exp_q[0] = 8'h41;
        exp_q[1] = 8'h42;
        exp_q[2] = 8'h0D;
        exp_q[3] = 8'h78;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("t4_dout", dout, exp_q[k]);
            chk("t4_re1", re1, (k == 2) ? 1 : 0);
        end
        re = 1'b0;

        // Forced release after MAX_LINE bytes.
        do_reset();
        for (int k = 0; k < 8; k++) q0[k] = 8'h61 + 8'(k);
        q1[0] = 8'h7A;
        q1[1] = 8'h0D;
        exp_q[0] = 8'h61;
        exp_q[1] = 8'h62;
        exp_q[2] = 8'h63;
        exp_q[3] = 8'h64;
        exp_q[4] = 8'h7A;
        exp_q[5] = 8'h0D;
        exp_q[6] = 8'h65;
        exp_q[7] = 8'h66;
        exp_q[8] = 8'h67;
        exp_q[9] = 8'h68;
        setup(8, 2);
        re = 1'b1;
        drain("t5", 10);
        re = 1'b0;
`endif

        prot_en = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
